// File: rtl/avg_arb_pkg.sv
// Shared constants and per-channel state record for the multi-channel
// 8-sample moving-average scheduler.
package avg_arb_pkg;

    localparam int WIN      = 8;
    localparam int WIN_LOG2 = 3;
    localparam int DATA_W   = 8;
    localparam int SUM_W    = 11;

    // One channel's private window: sample history, write slot, running sum,
    // and whether the window has been seeded by its first sample.
    typedef struct packed {
        logic [WIN-1:0][DATA_W-1:0] hist;
        logic [WIN_LOG2-1:0]        wr_ptr;
        logic [SUM_W-1:0]           sum;
        logic                       primed;
    } chan_state_t;

endpackage

// File: rtl/avg_chan_arb_if.sv
// Sample-request / clear / averaged-result bundle between producers,
// the avg_chan_arb scheduler and downstream consumers.
interface avg_chan_arb_if
    import avg_arb_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = $clog2(NCH)
);

    logic [NCH-1:0]        in_valid;
    logic [NCH*DATA_W-1:0] num_in;
    logic [NCH-1:0]        in_ready;
    logic                  clr_valid;
    logic [CW-1:0]         clr_ch;
    logic [DATA_W-1:0]     ave8;
    logic                  out_valid;
    logic [CW-1:0]         out_ch;

    modport master (
        output in_valid, num_in, clr_valid, clr_ch,
        input  in_ready, ave8, out_valid, out_ch
    );

    modport slave (
        input  in_valid, num_in, clr_valid, clr_ch,
        output in_ready, ave8, out_valid, out_ch
    );

endinterface

// File: rtl/avg_rr_arb.sv
// Combinational round-robin picker: first unmasked request at or after ptr,
// wrapping, as a one-hot grant plus its index.
module avg_rr_arb #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx,
    output logic         any
);

    logic [N-1:0] w_eff;

    assign w_eff = req & ~mask;

    // Walk the requests starting at ptr and keep only the first hit.
    always_comb begin
        int j;
        j       = 0;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!any && w_eff[j]) begin
                any     = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = W'(j);
            end
        end
    end

endmodule

// File: rtl/avg_chan_arb.sv
// avg_chan_arb: one shared 8-sample moving-average datapath time-multiplexed
// over NCH requesters in round-robin order; results tagged with channel.
// Optional feature macro: AVG_ARB_PRIME_EN (first sample seeds the window).
module avg_chan_arb
    import avg_arb_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = $clog2(NCH)
) (
    input  logic          clk,
    input  logic          rs,
    avg_chan_arb_if.slave bus
);

    chan_state_t         r_st [NCH];
    logic [CW-1:0]       r_rr_ptr;
    logic [DATA_W-1:0]   r_ave8;
    logic [CW-1:0]       r_out_ch;
    logic                r_out_valid;

    logic                w_clr_hit;
    logic [NCH-1:0]      w_clr_mask;
    logic [NCH-1:0]      w_gnt;
    logic [CW-1:0]       w_idx;
    logic                w_any;
    logic                w_acc;
    chan_state_t         w_cur;
    logic [DATA_W-1:0]   w_x;
    logic [DATA_W-1:0]   w_old;
    logic [SUM_W-1:0]    w_sum_new;

    assign w_clr_hit = bus.clr_valid && (int'(bus.clr_ch) < NCH);

    // A channel being cleared this cycle is hidden from arbitration.
    always_comb begin
        w_clr_mask = '0;
        if (w_clr_hit) w_clr_mask[bus.clr_ch] = 1'b1;
    end

    avg_rr_arb #(.N(NCH), .W(CW)) u_arb (
        .req     (bus.in_valid),
        .mask    (w_clr_mask),
        .ptr     (r_rr_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_idx),
        .any     (w_any)
    );

    assign w_acc        = w_any & ~rs;
    assign bus.in_ready = w_gnt & {NCH{~rs}};

    // Running-sum update for the granted channel: add new, drop oldest.
    always_comb begin
        w_cur     = r_st[w_idx];
        w_x       = bus.num_in[int'(w_idx)*DATA_W +: DATA_W];
        w_old     = w_cur.hist[w_cur.wr_ptr];
        w_sum_new = w_cur.sum + SUM_W'(w_x) - SUM_W'(w_old);
`ifdef AVG_ARB_PRIME_EN
        if (!w_cur.primed) w_sum_new = SUM_W'(w_x) << WIN_LOG2;
`endif
    end

`ifndef AVG_ARB_PRIME_EN
    logic w_unused_primed;
    assign w_unused_primed = w_cur.primed;
`endif

    // Channel state, round-robin pointer and registered result.
    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            for (int k = 0; k < NCH; k++) r_st[k] <= '0;
            r_rr_ptr    <= '0;
            r_ave8      <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_acc;
            if (w_clr_hit) r_st[bus.clr_ch] <= '0;
            if (w_acc) begin
`ifdef AVG_ARB_PRIME_EN
                if (!w_cur.primed) begin
                    for (int e = 0; e < WIN; e++) r_st[w_idx].hist[e] <= w_x;
                    r_st[w_idx].primed <= 1'b1;
                end else begin
                    r_st[w_idx].hist[w_cur.wr_ptr] <= w_x;
                end
`else
                r_st[w_idx].hist[w_cur.wr_ptr] <= w_x;
`endif
                r_st[w_idx].wr_ptr <= w_cur.wr_ptr + 3'd1;
                r_st[w_idx].sum    <= w_sum_new;
                r_ave8             <= w_sum_new[SUM_W-1:WIN_LOG2];
                r_out_ch           <= w_idx;
                r_rr_ptr           <= (int'(w_idx) == NCH - 1) ? '0 : w_idx + 1'b1;
            end
        end
    end

    assign bus.ave8      = r_ave8;
    assign bus.out_ch    = r_out_ch;
    assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_avg_chan_arb.sv
// Directed bench for avg_chan_arb (NCH = 4); expectations hand-computed for
// both settings of AVG_ARB_PRIME_EN.
module tb_avg_chan_arb;

    localparam int NCH = 4;
    localparam int CW  = 2;

    logic clk = 1'b0;
    logic rs;

    always #5 clk = ~clk;

    avg_chan_arb_if #(.NCH(NCH), .CW(CW)) bus ();

    avg_chan_arb #(.NCH(NCH), .CW(CW)) dut (
        .clk (clk),
        .rs  (rs),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

`ifdef AVG_ARB_PRIME_EN
    logic [7:0] e_ch0 [9]  = '{100, 100, 100, 100, 100, 100, 100, 100, 90};
    logic [7:0] e_ch1 [16] = '{255, 255, 255, 255, 255, 255, 255, 255,
                               223, 191, 159, 127, 95, 63, 31, 0};
    logic [7:0] e_ch2 [2]  = '{200, 187};
    logic [7:0] e_all [8]  = '{40, 8, 16, 24, 40, 8, 16, 24};
    logic [7:0] e_clr      = 8'd80;
`else
    logic [7:0] e_ch0 [9]  = '{12, 25, 37, 50, 62, 75, 87, 100, 90};
    logic [7:0] e_ch1 [16] = '{31, 63, 95, 127, 159, 191, 223, 255,
                               223, 191, 159, 127, 95, 63, 31, 0};
    logic [7:0] e_ch2 [2]  = '{25, 37};
    logic [7:0] e_all [8]  = '{5, 1, 2, 3, 10, 2, 4, 6};
    logic [7:0] e_clr      = 8'd10;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [NCH-1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2, input logic [7:0] d3);
        bus.in_valid = v;
        bus.num_in   = {d3, d2, d1, d0};
    endtask

    initial begin
        logic [7:0] d;
        int ch;
        rs            = 1'b1;
        bus.clr_valid = 1'b0;
        bus.clr_ch    = '0;
        drive(4'b1111, 8'd1, 8'd2, 8'd3, 8'd4);
        tick();
        tick();
        chk("rst_ave8",      bus.ave8,      0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_ch",    bus.out_ch,    0);
        chk("rst_in_ready",  bus.in_ready,  0);

        // channel 0 alone: eight 100s then a 20
        drive(4'b0001, 8'd100, 8'd0, 8'd0, 8'd0);
        @(negedge clk);
        rs = 1'b0;
        for (int i = 0; i < 9; i++) begin
            d = (i < 8) ? 8'd100 : 8'd20;
            drive(4'b0001, d, 8'd0, 8'd0, 8'd0);
            #1;
            chk("ch0_in_ready", bus.in_ready, 4'b0001);
            tick();
            chk("ch0_ave8",      bus.ave8,      e_ch0[i]);
            chk("ch0_out_ch",    bus.out_ch,    0);
            chk("ch0_out_valid", bus.out_valid, 1);
        end
        drive(4'b0000, 8'd0, 8'd0, 8'd0, 8'd0);
        tick();
        chk("idle_out_valid", bus.out_valid, 0);
        chk("idle_ave8_hold", bus.ave8,      90);

        // channel 1: full-scale fill then drain
        for (int i = 0; i < 16; i++) begin
            d = (i < 8) ? 8'd255 : 8'd0;
            drive(4'b0010, 8'd0, d, 8'd0, 8'd0);
            #1;
            chk("ch1_in_ready", bus.in_ready, 4'b0010);
            tick();
            chk("ch1_ave8",   bus.ave8,   e_ch1[i]);
            chk("ch1_out_ch", bus.out_ch, 1);
        end

        // channel 2: 200 then 100
        drive(4'b0100, 8'd0, 8'd0, 8'd200, 8'd0);
        tick();
        chk("ch2_first_ave8", bus.ave8,   e_ch2[0]);
        chk("ch2_first_ch",   bus.out_ch, 2);
        drive(4'b0100, 8'd0, 8'd0, 8'd100, 8'd0);
        tick();
        chk("ch2_second_ave8", bus.ave8, e_ch2[1]);

        // mid-stream asynchronous reset after 5 samples on channel 0
        drive(4'b0001, 8'd10, 8'd0, 8'd0, 8'd0);
        repeat (5) tick();
        chk("pre_rst_out_valid", bus.out_valid, 1);
        rs = 1'b1;
        #1;
        chk("async_rst_ave8",      bus.ave8,      0);
        chk("async_rst_out_valid", bus.out_valid, 0);
        chk("async_rst_in_ready",  bus.in_ready,  0);
        tick();
        drive(4'b1111, 8'd40, 8'd8, 8'd16, 8'd24);
        @(negedge clk);
        rs = 1'b0;
        #1;

        // all channels valid: rotation from channel 0, fresh histories
        for (int c = 0; c < 8; c++) begin
            ch = c % NCH;
            chk("rr_in_ready", bus.in_ready, 32'(1) << ch);
            tick();
            chk("rr_out_valid", bus.out_valid, 1);
            chk("rr_out_ch",    bus.out_ch,    ch);
            chk("rr_ave8",      bus.ave8,      e_all[c]);
        end

        // clear channel 3 while it is the only requester
        drive(4'b1000, 8'd0, 8'd0, 8'd0, 8'd80);
        bus.clr_valid = 1'b1;
        bus.clr_ch    = 2'd3;
        #1;
        chk("clr_in_ready", bus.in_ready, 0);
        tick();
        chk("clr_out_valid", bus.out_valid, 0);
        bus.clr_valid = 1'b0;
        #1;
        chk("post_clr_in_ready", bus.in_ready, 4'b1000);
        tick();
        chk("post_clr_ave8",      bus.ave8,      e_clr);
        chk("post_clr_out_ch",    bus.out_ch,    3);
        chk("post_clr_out_valid", bus.out_valid, 1);

        drive(4'b0000, 8'd0, 8'd0, 8'd0, 8'd0);
        tick();
        chk("end_out_valid", bus.out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
